// File: rtl/execute_pipe.sv
// Execute stage for the RV64 Zba core: single-cycle ALU/branch/address ops, a shift-add
// multiplier, and a one-entry output register with valid/ready on both sides.
module execute_pipe #(
    parameter int XLEN       = 64,
    parameter int MUL_STEP   = 4,
    parameter int ENABLE_ZBA = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] imm_s,
    input  logic [XLEN-1:0] imm_b,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_out,
    output logic            mem_we,
    output logic            mem_to_reg,
    output logic            rd_we,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_offset
);
    localparam int MUL_ITERS = XLEN / MUL_STEP;
    localparam int CNT_W     = $clog2(MUL_ITERS) + 1;
    localparam bit ZBA_EN    = (ENABLE_ZBA != 0);
    localparam bit ADDUW_EN  = ZBA_EN && (XLEN == 64);
    localparam logic [XLEN-1:0] LOW32_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {IDLE, MUL_BUSY} state_t;

    state_t            state_reg;
    logic              out_valid_reg;
    logic [XLEN-1:0]   alu_result_reg;
    logic [XLEN-1:0]   store_data_reg;
    logic [4:0]        rd_out_reg;
    logic              mem_we_reg;
    logic              mem_to_reg_reg;
    logic              rd_we_reg;
    logic              branch_taken_reg;
    logic [XLEN-1:0]   branch_offset_reg;

    logic [XLEN-1:0]   mul_mcand_reg;
    logic [XLEN-1:0]   mul_mplier_reg;
    logic [XLEN-1:0]   mul_acc_reg;
    logic [CNT_W-1:0]  mul_count_reg;
    logic [XLEN-1:0]   mul_acc_next;
    logic [XLEN-1:0]   pp_sum;
    logic [XLEN-1:0]   pp [MUL_STEP];

    logic [XLEN-1:0]   dec_result;
    logic              dec_mem_we;
    logic              dec_mem_to_reg;
    logic              dec_rd_we;
    logic              dec_branch;
    logic              dec_is_mul;
    logic              accept;

    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    // Decode and single-cycle datapath; anything unrecognised falls through as an all-zero bubble.
    always_comb begin
        dec_result     = '0;
        dec_mem_we     = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_rd_we      = 1'b0;
        dec_branch     = 1'b0;
        dec_is_mul     = 1'b0;
        case (opcode)
            OPC_OP: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: begin
                        dec_result = rs1_data + rs2_data;
                        dec_rd_we  = 1'b1;
                    end
                    {7'b0000000, 3'b111}: begin
                        dec_result = rs1_data & rs2_data;
                        dec_rd_we  = 1'b1;
                    end
                    {7'b0000000, 3'b110}: begin
                        dec_result = rs1_data | rs2_data;
                        dec_rd_we  = 1'b1;
                    end
                    {7'b0100000, 3'b000}: begin
                        dec_result = rs1_data - rs2_data;
                        dec_rd_we  = 1'b1;
                    end
                    {7'b0010000, 3'b010}: begin
                        if (ZBA_EN) begin
                            dec_result = (rs1_data << 1) + rs2_data;
                            dec_rd_we  = 1'b1;
                        end
                    end
                    {7'b0010000, 3'b100}: begin
                        if (ZBA_EN) begin
                            dec_result = (rs1_data << 2) + rs2_data;
                            dec_rd_we  = 1'b1;
                        end
                    end
                    {7'b0010000, 3'b110}: begin
                        if (ZBA_EN) begin
                            dec_result = (rs1_data << 3) + rs2_data;
                            dec_rd_we  = 1'b1;
                        end
                    end
                    {7'b0000001, 3'b000}: begin
                        dec_is_mul = 1'b1;
                        dec_rd_we  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OPC_OP32: begin
                if (ADDUW_EN && funct7 == 7'b0000100 && funct3 == 3'b000) begin
                    dec_result = (rs1_data & LOW32_MASK) + rs2_data;
                    dec_rd_we  = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b000) begin
                    dec_result = rs1_data + imm_i;
                    dec_rd_we  = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_result     = rs1_data + imm_i;
                dec_mem_to_reg = 1'b1;
                dec_rd_we      = 1'b1;
            end
            OPC_STORE: begin
                dec_result = rs1_data + imm_s;
                dec_mem_we = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  dec_branch = (rs1_data == rs2_data);
                    3'b001:  dec_branch = (rs1_data != rs2_data);
                    3'b100:  dec_branch = ($signed(rs1_data) < $signed(rs2_data));
                    3'b101:  dec_branch = !($signed(rs1_data) < $signed(rs2_data));
                    default: dec_branch = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // One partial product per multiplier bit retired this cycle.
    generate
        for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign pp[gi] = mul_mplier_reg[gi] ? (mul_mcand_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            pp_sum = pp_sum + pp[i];
        end
        mul_acc_next = mul_acc_reg + pp_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            out_valid_reg     <= 1'b0;
            alu_result_reg    <= '0;
            store_data_reg    <= '0;
            rd_out_reg        <= '0;
            mem_we_reg        <= 1'b0;
            mem_to_reg_reg    <= 1'b0;
            rd_we_reg         <= 1'b0;
            branch_taken_reg  <= 1'b0;
            branch_offset_reg <= '0;
            mul_mcand_reg     <= '0;
            mul_mplier_reg    <= '0;
            mul_acc_reg       <= '0;
            mul_count_reg     <= '0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        store_data_reg    <= rs2_data;
                        branch_offset_reg <= imm_b;
                        rd_out_reg        <= rd_in;
                        mem_we_reg        <= dec_mem_we;
                        mem_to_reg_reg    <= dec_mem_to_reg;
                        rd_we_reg         <= dec_rd_we;
                        branch_taken_reg  <= dec_branch;
                        if (dec_is_mul) begin
                            // The slot is empty or draining this edge, so the result can land later.
                            state_reg      <= MUL_BUSY;
                            out_valid_reg  <= 1'b0;
                            mul_mcand_reg  <= rs1_data;
                            mul_mplier_reg <= rs2_data;
                            mul_acc_reg    <= '0;
                            mul_count_reg  <= '0;
                        end else begin
                            alu_result_reg <= dec_result;
                            out_valid_reg  <= 1'b1;
                        end
                    end
                end
                MUL_BUSY: begin
                    mul_acc_reg    <= mul_acc_next;
                    mul_mcand_reg  <= mul_mcand_reg << MUL_STEP;
                    mul_mplier_reg <= mul_mplier_reg >> MUL_STEP;
                    mul_count_reg  <= mul_count_reg + CNT_W'(1);
                    if (mul_count_reg == CNT_W'(MUL_ITERS - 1)) begin
                        alu_result_reg <= mul_acc_next;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid     = out_valid_reg;
    assign alu_result    = alu_result_reg;
    assign store_data    = store_data_reg;
    assign rd_out        = rd_out_reg;
    assign mem_we        = mem_we_reg;
    assign mem_to_reg    = mem_to_reg_reg;
    assign rd_we         = rd_we_reg;
    assign branch_taken  = branch_taken_reg;
    assign branch_offset = branch_offset_reg;
endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: a vector table for single-cycle ops plus hand-written
// sequences for the multiplier, backpressure and reset-during-multiply cases.
module tb_execute_pipe;
    localparam logic [6:0] OP = 7'h33, OP32 = 7'h3B, OPIMM = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] rs1_data = '0, rs2_data = '0, imm_i = '0, imm_s = '0, imm_b = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] alu_result, store_data, branch_offset;
    logic [4:0]  rd_out;
    logic        mem_we, mem_to_reg, rd_we, branch_taken;

    always #5 clk = ~clk;

    execute_pipe #(.XLEN(64), .MUL_STEP(4), .ENABLE_ZBA(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .store_data(store_data), .rd_out(rd_out), .mem_we(mem_we), .mem_to_reg(mem_to_reg),
        .rd_we(rd_we), .branch_taken(branch_taken), .branch_offset(branch_offset)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        opcode = opc; funct3 = f3; funct7 = f7;
        rs1_data = a; rs2_data = b; rd_in = rd;
        imm_i = '0; imm_s = '0; imm_b = '0;
    endtask

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] a, b, ii, is, ib;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        mw, mtr, rw, br;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] ii, input logic [63:0] is, input logic [63:0] ib,
                                input logic [4:0] rd, input logic [63:0] res,
                                input logic mw, input logic mtr, input logic rw, input logic br);
        vec_t v;
        v.name = name; v.opc = opc; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
        v.ii = ii; v.is = is; v.ib = ib; v.rd = rd; v.res = res;
        v.mw = mw; v.mtr = mtr; v.rw = rw; v.br = br;
        return v;
    endfunction

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [63:0] bp_a [3] = '{64'd1, 64'd10, 64'd100};
    logic [63:0] bp_b [3] = '{64'd1, 64'd10, 64'd200};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_low;
        int offered, drained, first_drain, last_drain, spurious;

        vecs.push_back(mk("ADD",     OP,    3'b000, 7'h00, 64'd5, 64'd7, 0, 0, 64'h11, 5'd3, 64'd12, 0, 0, 1, 0));
        vecs.push_back(mk("SH3ADD",  OP,    3'b110, 7'h10, 64'h10, 64'd3, 0, 0, 64'h12, 5'd4, 64'h83, 0, 0, 1, 0));
        vecs.push_back(mk("SH1ADD",  OP,    3'b010, 7'h10, 64'd3, 64'd4, 0, 0, 64'h13, 5'd5, 64'd10, 0, 0, 1, 0));
        vecs.push_back(mk("SH2ADD",  OP,    3'b100, 7'h10, 64'd3, 64'd4, 0, 0, 64'h14, 5'd6, 64'd16, 0, 0, 1, 0));
        vecs.push_back(mk("ADD.UW",  OP32,  3'b000, 7'h04, 64'hFFFF_FFFF_8000_0000, 64'd1, 0, 0, 64'h15, 5'd7,
                          64'h8000_0001, 0, 0, 1, 0));
        vecs.push_back(mk("SUB",     OP,    3'b000, 7'h20, 64'd0, 64'd1, 0, 0, 64'h16, 5'd8,
                          64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0));
        vecs.push_back(mk("AND",     OP,    3'b111, 7'h00, 64'hF0F0, 64'hFF00, 0, 0, 64'h17, 5'd9, 64'hF000, 0, 0, 1, 0));
        vecs.push_back(mk("OR",      OP,    3'b110, 7'h00, 64'hF0, 64'h0F, 0, 0, 64'h18, 5'd10, 64'hFF, 0, 0, 1, 0));
        vecs.push_back(mk("ADDI",    OPIMM, 3'b000, 7'h00, 64'd10, 64'd99, 64'hFFFF_FFFF_FFFF_FFFD, 0, 64'h19,
                          5'd11, 64'd7, 0, 0, 1, 0));
        vecs.push_back(mk("LOAD",    LD,    3'b011, 7'h00, 64'h1000, 64'd0, 64'd8, 0, 64'h1A, 5'd12,
                          64'h1008, 0, 1, 1, 0));
        vecs.push_back(mk("STORE",   ST,    3'b011, 7'h00, 64'h2000, 64'hDEAD_BEEF, 0, 64'hFFFF_FFFF_FFFF_FFFC,
                          64'h1B, 5'd13, 64'h1FFC, 1, 0, 0, 0));
        vecs.push_back(mk("BLT",     BR,    3'b100, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0,
                          64'hFFFF_FFFF_FFFF_FFF0, 5'd0, 64'd0, 0, 0, 0, 1));
        vecs.push_back(mk("BGE",     BR,    3'b101, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'h40,
                          5'd0, 64'd0, 0, 0, 0, 0));
        vecs.push_back(mk("BNE",     BR,    3'b001, 7'h00, 64'd4, 64'd4, 0, 0, 64'h80, 5'd0, 64'd0, 0, 0, 0, 0));
        vecs.push_back(mk("BEQ",     BR,    3'b000, 7'h00, 64'd4, 64'd4, 0, 0, 64'h84, 5'd0, 64'd0, 0, 0, 0, 1));
        vecs.push_back(mk("UNS_IMM", OPIMM, 3'b001, 7'h00, 64'd5, 64'd5, 64'd1, 0, 64'h20, 5'd14, 64'd0, 0, 0, 0, 0));
        vecs.push_back(mk("UNS_OP",  OP,    3'b001, 7'h00, 64'd5, 64'd5, 0, 0, 64'h21, 5'd15, 64'd0, 0, 0, 0, 0));
        vecs.push_back(mk("UNS_ZBA", OP,    3'b000, 7'h10, 64'd5, 64'd5, 0, 0, 64'h22, 5'd16, 64'd0, 0, 0, 0, 0));

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset alu_result", alu_result, 0);
        check("reset store_data", store_data, 0);
        check("reset rd_out", rd_out, 0);
        check("reset flags", {mem_we, mem_to_reg, rd_we, branch_taken}, 0);
        check("reset branch_offset", branch_offset, 0);
        $display("reset done");

        // Table-driven single-cycle ops, streamed back to back
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].opc; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
            rs1_data = vecs[i].a; rs2_data = vecs[i].b;
            imm_i = vecs[i].ii; imm_s = vecs[i].is; imm_b = vecs[i].ib; rd_in = vecs[i].rd;
            in_valid = 1'b1;
            #1;
            check({vecs[i].name, " in_ready"}, in_ready, 1);
            @(negedge clk);
            #1;
            check({vecs[i].name, " out_valid"}, out_valid, 1);
            check({vecs[i].name, " alu_result"}, alu_result, vecs[i].res);
            check({vecs[i].name, " flags"}, {mem_we, mem_to_reg, rd_we, branch_taken},
                  {vecs[i].mw, vecs[i].mtr, vecs[i].rw, vecs[i].br});
            check({vecs[i].name, " store_data"}, store_data, vecs[i].b);
            check({vecs[i].name, " branch_offset"}, branch_offset, vecs[i].ib);
            check({vecs[i].name, " rd_out"}, rd_out, vecs[i].rd);
            $display("vec %-8s result=0x%h flags=%b rd=%0d", vecs[i].name, alu_result,
                     {mem_we, mem_to_reg, rd_we, branch_taken}, rd_out);
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("drain out_valid", out_valid, 0);

        // MUL: 16 busy cycles, then result; a following ADD waits until IDLE
        set_op(OP, 3'b000, 7'h01, 64'h1_0000_0003, 64'd6, 5'd9);
        in_valid = 1'b1;
        #1;
        check("mul in_ready", in_ready, 1);
        @(negedge clk);
        #1;
        set_op(OP, 3'b000, 7'h00, 64'd100, 64'd23, 5'd10);
        busy_low = 0;
        for (int k = 0; k < 16; k++) begin
            if (in_ready === 1'b0 && out_valid === 1'b0) busy_low++;
            if (k < 15) begin
                @(negedge clk);
                #1;
            end
        end
        check("mul busy cycles", busy_low, 16);
        @(negedge clk);
        #1;
        check("mul out_valid", out_valid, 1);
        check("mul alu_result", alu_result, 64'h6_0000_0012);
        check("mul rd_out", rd_out, 9);
        check("mul rd_we", rd_we, 1);
        check("mul in_ready after", in_ready, 1);
        $display("mul result=0x%h rd=%0d", alu_result, rd_out);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        check("post-mul add result", alu_result, 64'd123);
        check("post-mul add rd_out", rd_out, 10);
        $display("add after mul result=%0d rd=%0d", alu_result, rd_out);
        @(negedge clk);
        #1;
        check("post-mul drain", out_valid, 0);

        // Backpressure: three ADDs, out_ready low for the first five cycles
        offered = 0; drained = 0; first_drain = -1; last_drain = -1; spurious = 0;
        for (int cyc = 0; cyc < 30 && drained < 3; cyc++) begin
            out_ready = (cyc >= 5);
            if (offered < 3) begin
                set_op(OP, 3'b000, 7'h00, bp_a[offered], bp_b[offered], 5'(offered + 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    spurious++;
                end else if (out_ready) begin
                    check("bp drain result", alu_result, sb[0].res);
                    check("bp drain rd_out", rd_out, sb[0].rd);
                    $display("bp drain cyc=%0d result=%0d rd=%0d", cyc, alu_result, rd_out);
                    void'(sb.pop_front());
                    drained++;
                    if (first_drain < 0) first_drain = cyc;
                    last_drain = cyc;
                end else begin
                    check("bp stall in_ready", in_ready, 0);
                    check("bp held result", alu_result, sb[0].res);
                    check("bp held rd_out", rd_out, sb[0].rd);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{res: bp_a[offered] + bp_b[offered], rd: 5'(offered + 1)});
                offered++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp drained count", drained, 3);
        check("bp back-to-back", last_drain - first_drain, 2);
        check("bp spurious outputs", spurious, 0);
        check("bp scoreboard empty", sb.size(), 0);

        // Reset during the fifth cycle of a MUL
        #1;
        out_ready = 1'b1;
        set_op(OP, 3'b000, 7'h01, 64'd7, 64'd9, 5'd17);
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort alu_result", alu_result, 0);
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (out_valid !== 1'b0) spurious++;
        end
        check("abort no late result", spurious, 0);
        $display("mul aborted by reset");
        set_op(OP, 3'b000, 7'h00, 64'd2, 64'd2, 5'd18);
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        check("after-reset add out_valid", out_valid, 1);
        check("after-reset add result", alu_result, 64'd4);
        check("after-reset add rd_out", rd_out, 18);
        $display("add after reset result=%0d", alu_result);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
